// File: rtl/io_pkg.sv
// Shared IO definitions for the switch/button front end.
// Button FSM states, debounce default and switch MMIO map.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // 10 ms at 100 MHz
  localparam int DB_COUNT_DEFAULT = 1000000;

  localparam logic [31:0] SW_LIVE_ADDR   = 32'h1000_0000;
  localparam logic [31:0] SW_SNAP_ADDR   = 32'h1000_0004;
  localparam logic [31:0] SW_STATUS_ADDR = 32'h1000_0008;

endpackage

// File: rtl/sync2_debounce.sv
// Two-flop synchroniser plus shared stable counter for a bus.
// A new level is accepted after DB_COUNT unchanged cycles.
module sync2_debounce #(
  parameter int WIDTH    = 1,
  parameter int DB_COUNT = 4,
  parameter int CNT_W    = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] stable_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_COUNT - 1);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // count consecutive unchanged samples that differ from stable
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (sync_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      stable_d = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // synchroniser, history and debounce state
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q   <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= d_i;
      sync_q   <= meta_q;
      prev_q   <= sync_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sync_o   = sync_q;
  assign stable_o = stable_q;

endmodule

// File: rtl/switch_input_conditioner.sv
// Switch/button conditioning: debounced switch word,
// confirm pulse, press-time snapshot and sticky valid flag.
module switch_input_conditioner
  import io_pkg::*;
#(
  parameter int SW_WIDTH = 16,
  parameter int DB_COUNT = DB_COUNT_DEFAULT,
  parameter int CNT_W    = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] sw_raw,
  input  logic                btn_raw,
  input  logic                rd_ack,
  output logic [SW_WIDTH-1:0] sw_stable,
  output logic [SW_WIDTH-1:0] sw_snapshot,
  output logic                confirm_pulse,
  output logic                snapshot_valid
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_COUNT - 1);

  logic [SW_WIDTH-1:0] sw_s_unused;
  logic                btn_s;
  logic                btn_db_unused;

  sync2_debounce #(
    .WIDTH    (SW_WIDTH),
    .DB_COUNT (DB_COUNT),
    .CNT_W    (CNT_W)
  ) u_sw (
    .clk      (clk),
    .rst      (rst),
    .d_i      (sw_raw),
    .sync_o   (sw_s_unused),
    .stable_o (sw_stable)
  );

  sync2_debounce #(
    .WIDTH    (1),
    .DB_COUNT (DB_COUNT),
    .CNT_W    (CNT_W)
  ) u_btn (
    .clk      (clk),
    .rst      (rst),
    .d_i      (btn_raw),
    .sync_o   (btn_s),
    .stable_o (btn_db_unused)
  );

  btn_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                conf_q, conf_d;
  logic [SW_WIDTH-1:0] snap_q, snap_d;
  logic                valid_q, valid_d;

  // button FSM next state, confirm pulse and snapshot capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    conf_d  = 1'b0;
    snap_d  = snap_q;
    valid_d = valid_q & ~rd_ack;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          conf_d  = 1'b1;
          snap_d  = sw_stable;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      conf_q  <= 1'b0;
      snap_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      conf_q  <= conf_d;
      snap_q  <= snap_d;
      valid_q <= valid_d;
    end
  end

  assign confirm_pulse  = conf_q;
  assign sw_snapshot    = snap_q;
  assign snapshot_valid = valid_q;

endmodule
